// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped GPIO with synchronised, debounced buttons, W1C press latching and LED outputs.
// Define GPIO_PWM_EN to add an 8-bit PWM duty register (offset 3) that dims the LED outputs.
module gpio_mmio #(
    parameter int          N_BTN      = 4,
    parameter int          N_LED      = 4,
    parameter logic [15:0] BASE       = 16'h6000,
    parameter int          DEB_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      address,
    input  logic [15:0]      in,
    input  logic             load,
    output logic [15:0]      out,
    output logic             hit,
    input  logic [N_BTN-1:0] btn,
    output logic [N_LED-1:0] led,
    output logic             irq
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [N_BTN-1:0] sync1, sync2, state, edge_q, rise_q, toggle, clr;
    logic [CW-1:0]    cnt [N_BTN];
    logic [N_LED-1:0] led_q;
    logic [1:0]       off;
    logic             we;

    assign hit = address[15:2] == BASE[15:2];
    assign off = address[1:0];
    assign we  = load && hit;
    assign clr = (we && off == 2'd1) ? in[N_BTN-1:0] : '0;
    assign irq = |edge_q;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_BTN; i++)
            toggle[i] = (sync2[i] != state[i]) && (cnt[i] == CW'(DEB_CYCLES - 1));
    end

    // rise_q delays the press event one cycle so EDGE follows STATE; set beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            state  <= '0;
            rise_q <= '0;
            edge_q <= '0;
            led_q  <= '0;
            for (int i = 0; i < N_BTN; i++)
                cnt[i] <= '0;
        end else begin
            sync1  <= ~btn;
            sync2  <= sync1;
            state  <= state ^ toggle;
            rise_q <= toggle & ~state;
            edge_q <= (edge_q & ~clr) | rise_q;
            if (we && off == 2'd2)
                led_q <= in[N_LED-1:0];
            for (int i = 0; i < N_BTN; i++)
                cnt[i] <= (sync2[i] == state[i] || toggle[i]) ? '0 : cnt[i] + 1'b1;
        end
    end

`ifdef GPIO_PWM_EN
    logic [7:0] pwm_cnt, duty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            duty    <= 8'hFF;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (we && off == 2'd3)
                duty <= in[7:0];
        end
    end

    assign led = led_q & {N_LED{duty == 8'hFF || pwm_cnt < duty}};
`else
    assign led = led_q;
`endif

    always_comb begin
        out = '0;
        if (hit && off == 2'd0) out[N_BTN-1:0] = state;
        if (hit && off == 2'd1) out[N_BTN-1:0] = edge_q;
        if (hit && off == 2'd2) out[N_LED-1:0] = led_q;
`ifdef GPIO_PWM_EN
        if (hit && off == 2'd3) out[7:0] = duty;
`endif
    end
endmodule
